muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the 5-stage MIPS pipeline: accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a shift-add multiplier or restoring divider over WIDTH cycles. It writes the 2×WIDTH result to HI/LO and raises a stall request to the hazard unit. The stall is raised whenever the pipeline issues a new mul/div or reads HI/LO while an operation is in flight.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  EX-stage mul/div instruction valid this cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- opa  in  WIDTH  rs value (multiplicand / dividend)
- opb  in  WIDTH  rt value (multiplier / divisor)
- mf_req  in  1  EX-stage MFHI/MFLO present this cycle
- busy  out  1  operation in flight
- stall  out  1  request to freeze PC, IF/ID and ID/EX and bubble EX/MEM
- done  out  1  one-cycle pulse: HI/LO just updated
- dz  out  1  last completed divide had divisor 0; held until next completion
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1 at an edge:
  - Latch the signed flag, the op kind, and the sign bits of opa and opb.
  - For signed ops, load the magnitudes of opa and opb; otherwise load the raw values.
  - Counter ← WIDTH−1; go to RUN.
- RUN, multiply: each cycle, if accumulator LSB=1, add the multiplicand to the upper half, then shift the {carry, acc} pair right by 1.
- RUN, divide: each cycle, shift the {rem, quot} pair left by 1, then trial-subtract the divisor from rem.
  - If the difference is non-negative, keep it and set the quotient LSB.
- RUN: when counter=0, go to FIX; otherwise decrement the counter.
- FIX, sign correction:
  - Signed multiply: negate the 2×WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; give the remainder the sign of the dividend.
- FIX, result: write HI ← upper/remainder and LO ← lower/quotient, then go to IDLE.
- Divisor 0, any divide:
  - Skip sign correction.
  - Result: HI=opa as captured (original signed value), LO=all ones.
  - Set dz=1. Any other completion clears dz.
- Signed −2^(WIDTH−1) / −1: LO=0x80000000, HI=0. Wrap, no trap.
- busy = (state≠IDLE).
- stall = busy & (start | mf_req), combinational.
- start while busy is ignored; the held instruction re-presents start after busy falls.
- hi/lo are stable outside the FIX edge. MFHI/MFLO read them directly when not stalled.

## Timing
- Reset (async, any state, including mid-RUN): state=IDLE, busy=0, stall=0, done=0, dz=0, hi=0, lo=0. The in-flight op is discarded.
- Start edge = T0.
  - busy=1 from T0 to T0+WIDTH+1.
  - hi/lo update at edge T0+WIDTH+1.
  - done=1 during cycle T0+WIDTH+1 (registered, one cycle); busy=0 in the same cycle.
- Latency is fixed at WIDTH+1 edges for every op, including divisor 0.
- Back-to-back ops: a start in the cycle busy falls is accepted at the next edge, so there are no dead cycles.
- mf_req in the done cycle is not stalled and sees the new HI/LO.
- The stall output has no register stage. The hazard unit ORs it with its load-use stall.

## Configuration
- MULDIV_DIV_EN defined: the divider datapath and DIV/DIVU are supported as above.
- MULDIV_DIV_EN undefined: divider logic is not compiled, and dz is tied to 0.
  - start with op[1]=1 is ignored: no state change, busy=0, no stall, hi/lo unchanged.
  - MULT/MULTU behaviour and latency are identical to the defined case.

## Test plan
- MULT opa=−3 (0xFFFFFFFD), opb=7 → after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one-cycle pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=100, dz=1.
- DIV 0x80000000 / −1 → lo=0x80000000, hi=0, dz=0.
- MULT started, mf_req asserted at T0+5 → stall=1 until busy falls; hi/lo read after the stall show the product.
- MULT started, then start re-asserted while busy → stall=1 and the second op begins at the done cycle.
- reset pulled low at T0+10 → all outputs 0 immediately; the next start behaves normally.
- With MULDIV_DIV_EN undefined, DIV start → busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide sequencer: shift-add multiplier and restoring divider over WIDTH cycles.
// Define MULDIV_DIV_EN to build the divider (DIV/DIVU); without it only MULT/MULTU are accepted.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic               is_signed, a_neg, b_neg, accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, acc_neg;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_DIV_EN
  logic               is_div, b_zero, dz_q;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub, quot_neg, rem_neg;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;

  assign accept = start;
  assign dz     = dz_q;
`else
  assign accept = start & ~op[1];
  assign dz     = 1'b0;
`endif

  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | mf_req);

  // op[0]=0 selects the signed variants, which run on magnitudes
  assign mag_a = (~op[0] & opa[WIDTH-1]) ? -opa : opa;
  assign mag_b = (~op[0] & opb[WIDTH-1]) ? -opb : opb;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_sum  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                      : {1'b0, acc[2*WIDTH-1:WIDTH]};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    acc_neg  = -acc;
    if (is_signed & (a_neg ^ b_neg)) {res_hi, res_lo} = acc_neg;
    else                             {res_hi, res_lo} = acc;
`ifdef MULDIV_DIV_EN
    // the shifted remainder needs one extra bit when the divisor's MSB is set
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_sub  = rem_sh[WIDTH-1:0] - opnd;
    div_next = rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    quot_neg = -acc[WIDTH-1:0];
    rem_neg  = -acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      // divide by zero leaves the dividend in rem, so the dividend-sign fixup restores opa
      res_hi = (is_signed & a_neg) ? rem_neg : acc[2*WIDTH-1:WIDTH];
      if (b_zero)                           res_lo = '1;
      else if (is_signed & (a_neg ^ b_neg)) res_lo = quot_neg;
      else                                  res_lo = acc[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      opnd      <= '0;
      cnt       <= '0;
      is_signed <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div    <= 1'b0;
      b_zero    <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      done <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_signed <= ~op[0];
            a_neg     <= opa[WIDTH-1];
            b_neg     <= opb[WIDTH-1];
            cnt       <= CW'(WIDTH - 1);
            acc       <= {{WIDTH{1'b0}}, mag_b};
            opnd      <= mag_a;
`ifdef MULDIV_DIV_EN
            is_div    <= op[1];
            b_zero    <= (opb == '0);
            if (op[1]) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end
`endif
          end
        end
        RUN: begin
`ifdef MULDIV_DIV_EN
          acc <= is_div ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          hi <= res_hi;
          lo <= res_lo;
`ifdef MULDIV_DIV_EN
          dz_q <= is_div & b_zero;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed MULT/MULTU (and DIV/DIVU when MULDIV_DIV_EN is defined),
// stall behaviour, back-to-back issue and asynchronous reset mid-operation.
module tb_muldiv_seq;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam int LATENCY = 33;

  logic        clock, reset, start, mf_req;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        busy, stall, done, dz;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          id;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          next_id = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .opa   (opa),
    .opb   (opb),
    .mf_req(mf_req),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.dz = edz;
    e.id = next_id;
    next_id++;
    sb.push_back(e);
    last_hi = ehi;
    last_lo = elo;
  endtask

  // called at a negedge after the start edge; counts edges until done is seen
  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int n;
    int id;
    id = next_id;
    @(negedge clock);
    op = o; opa = a; opb = b; start = 1'b1;
    pushExp(ehi, elo, edz);
    @(negedge clock);
    start = 1'b0;
    #1;
    checkOutput($sformatf("op%0d_busy", id), busy, 1);
    checkOutput($sformatf("op%0d_stall_quiet", id), stall, 0);
    waitDone(n);
    checkOutput($sformatf("op%0d_latency", id), n, LATENCY);
    checkOutput($sformatf("op%0d_busy_at_done", id), busy, 0);
    @(negedge clock);
    #1;
    checkOutput($sformatf("op%0d_done_pulse", id), done, 0);
  endtask

  // Scoreboard monitor: every done pulse consumes the oldest expected result
  always @(negedge clock) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput($sformatf("op%0d_hi", mon_e.id), hi, mon_e.hi);
        checkOutput($sformatf("op%0d_lo", mon_e.id), lo, mon_e.lo);
        checkOutput($sformatf("op%0d_dz", mon_e.id), dz, mon_e.dz);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int bad_st;
    reset = 1'b0; start = 1'b0; mf_req = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (2) @(negedge clock);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dz", dz, 0);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    @(negedge clock);
    reset = 1'b1;

    applyStimulus(OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    applyStimulus(OP_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'd30,        1'b0);
    applyStimulus(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0);

`ifdef MULDIV_DIV_EN
    applyStimulus(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
    applyStimulus(OP_DIVU, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1);
    @(negedge clock);
    checkOutput("dz_held", dz, 1);
    applyStimulus(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    applyStimulus(OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
`else
    @(negedge clock);
    op = OP_DIV; opa = 32'd77; opb = 32'd5; start = 1'b1;
    #1;
    checkOutput("nodiv_stall", stall, 0);
    @(negedge clock);
    #1;
    checkOutput("nodiv_busy", busy, 0);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("nodiv_busy_later", busy, 0);
    checkOutput("nodiv_done", done, 0);
    checkOutput("nodiv_hi", hi, last_hi);
    checkOutput("nodiv_lo", lo, last_lo);
`endif

    // MFHI/MFLO while a multiply is in flight
    @(negedge clock);
    op = OP_MULT; opa = 32'h7FFF_FFFF; opb = 32'd2; start = 1'b1;
    pushExp(32'h0000_0000, 32'hFFFF_FFFE, 1'b0);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    mf_req = 1'b1;
    n = 0; bad_st = 0;
    while (busy && n < 100) begin
      #1;
      if (stall !== 1'b1) bad_st++;
      @(negedge clock);
      n++;
    end
    #1;
    checkOutput("mf_stall_cycles", n, 29);
    checkOutput("mf_stall_drops", bad_st, 0);
    checkOutput("mf_done_stall", stall, 0);
    checkOutput("mf_done", done, 1);
    checkOutput("mf_read_hi", hi, 32'h0000_0000);
    checkOutput("mf_read_lo", lo, 32'hFFFF_FFFE);
    mf_req = 1'b0;

    // second mul/div held at start while busy, accepted straight after done
    @(negedge clock);
    op = OP_MULTU; opa = 32'h0001_0000; opb = 32'h0001_0000; start = 1'b1;
    pushExp(32'h0000_0001, 32'h0000_0000, 1'b0);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    op = OP_MULT; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF; start = 1'b1;
    pushExp(32'h0000_0000, 32'h0000_0001, 1'b0);
    n = 0; bad_st = 0;
    #1;
    while (!done && n < 100) begin
      if (stall !== 1'b1) bad_st++;
      @(negedge clock);
      #1;
      n++;
    end
    checkOutput("b2b_first_done", done, 1);
    checkOutput("b2b_stall_drops", bad_st, 0);
    checkOutput("b2b_done_stall", stall, 0);
    @(negedge clock);
    #1;
    checkOutput("b2b_accept", busy, 1);
    start = 1'b0;
    waitDone(n);
    checkOutput("b2b_latency", n, LATENCY);
    @(negedge clock);

    // asynchronous reset in the middle of a multiply
    @(negedge clock);
    op = OP_MULT; opa = 32'd9; opb = 32'd9; start = 1'b1;
    pushExp(32'd0, 32'd81, 1'b0);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_stall", stall, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_dz", dz, 0);
    checkOutput("midrst_hi", hi, 0);
    checkOutput("midrst_lo", lo, 0);
    void'(sb.pop_back());
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    repeat (2) @(negedge clock);
    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
